// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter.
//   state_e      - arbiter FSM states
//   *_D          - default widths / memory depth
//   PORT_DP/LD   - requester ids (datapath LSU, program loader)
package dmem_pkg;

  localparam int DATA_WIDTH_D = 32;
  localparam int ADDR_WIDTH_D = 32;
  localparam int NUM_WORDS_D  = 32;

  localparam logic PORT_DP = 1'b0;
  localparam logic PORT_LD = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// rr_arbiter2: two-input round-robin grant.
//   clk_i, rst_i  clock / async active-high reset
//   valid_i[1:0]  request present per port
//   en_i          arbitration allowed this cycle
//   gnt_o[1:0]    one-hot grant (zero when disabled or idle)
//   gnt_id_o      id of the port that would be granted
//   accept_o      a grant is taken this cycle; pointer moves past the winner
module rr_arbiter2
  import dmem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o,
  output logic       accept_o
);

  logic ptr_q;

  always_comb begin
    gnt_id_o = PORT_DP;
    if (&valid_i)        gnt_id_o = ptr_q;
    else if (valid_i[1]) gnt_id_o = PORT_LD;
    gnt_o = '0;
    if (en_i && |valid_i) gnt_o[gnt_id_o] = 1'b1;
  end

  assign accept_o = en_i & (|valid_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         ptr_q <= PORT_DP;
    else if (accept_o) ptr_q <= ~gnt_id_o;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port synchronous data memory between the
// datapath LSU (port 0) and the program loader (port 1), and sequences the
// memory's synchronous init.
//   clock/reset          system clock, async active-high reset
//   init_req/init_busy   re-init request / init pending-or-running
//   reqN_*               valid/ready request channel per port
//   rspN_*               one-cycle response pulse per port
//   mem_*                memory pins (position/writeData/memWrite/memRead/
//                        reset out, readData in)
// One access takes IDLE -> ISSUE -> RESP; memory strobes and responses are
// decoded from registered state only.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int NUM_WORDS  = NUM_WORDS_D
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  init_req,
  output logic                  init_busy,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp0_error,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  rsp1_error,
  output logic [ADDR_WIDTH-1:0] mem_position,
  output logic [DATA_WIDTH-1:0] mem_writeData,
  output logic                  mem_memWrite,
  output logic                  mem_memRead,
  output logic                  mem_reset,
  input  logic [DATA_WIDTH-1:0] mem_readData
);

  state_e state_q, state_d;
  logic   init_pending_q, init_pending_d;

  logic                  port_q, write_q, err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic       arb_en, accept, gnt_id, oor;
  logic [1:0] gnt;

  // Pending init blocks arbitration; reset gating keeps ready low while
  // requesters may already be driving valid.
  assign arb_en = (state_q == IDLE) && !init_pending_q && !reset;

  rr_arbiter2 u_arb (
    .clk_i    (clock),
    .rst_i    (reset),
    .valid_i  ({req1_valid, req0_valid}),
    .en_i     (arb_en),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .accept_o (accept)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign oor       = addr_q >= ADDR_WIDTH'(NUM_WORDS);
  assign init_busy = init_pending_q || (state_q == INIT);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      init_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      init_pending_q <= init_pending_d;
    end
  end

  // Next state
  always_comb begin
    state_d        = state_q;
    init_pending_d = init_pending_q | init_req;
    case (state_q)
      IDLE: begin
        if (init_pending_q) begin
          state_d        = INIT;
          // Clearing on entry wins: the init about to run covers a
          // request arriving in the same cycle.
          init_pending_d = 1'b0;
        end else if (accept) begin
          state_d = ISSUE;
        end
      end
      INIT:    state_d = IDLE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched request and error flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      port_q  <= PORT_DP;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        port_q  <= gnt_id;
        write_q <= gnt_id ? req1_write : req0_write;
        addr_q  <= gnt_id ? req1_addr  : req0_addr;
        wdata_q <= gnt_id ? req1_wdata : req0_wdata;
      end
      if (state_q == ISSUE) err_q <= oor;
    end
  end

  // Outputs
  always_comb begin
    mem_position  = '0;
    mem_writeData = '0;
    mem_memWrite  = 1'b0;
    mem_memRead   = 1'b0;
    mem_reset     = 1'b0;
    rsp0_valid    = 1'b0;
    rsp0_rdata    = '0;
    rsp0_error    = 1'b0;
    rsp1_valid    = 1'b0;
    rsp1_rdata    = '0;
    rsp1_error    = 1'b0;
    case (state_q)
      INIT: mem_reset = 1'b1;
      ISSUE: begin
        mem_position  = addr_q;
        mem_writeData = wdata_q;
        mem_memWrite  = !oor &&  write_q;
        mem_memRead   = !oor && !write_q;
      end
      RESP: begin
        // readData was registered by the memory at the end of ISSUE
        if (port_q == PORT_LD) begin
          rsp1_valid = 1'b1;
          rsp1_error = err_q;
          if (!write_q && !err_q) rsp1_rdata = mem_readData;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_error = err_q;
          if (!write_q && !err_q) rsp0_rdata = mem_readData;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboarded bench for dmem_arbiter with a behavioural 32-word
// synchronous memory (init loads word i with value i).
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        init_req, init_busy;
  logic        req0_valid, req0_ready, req0_write;
  logic [31:0] req0_addr, req0_wdata;
  logic        req1_valid, req1_ready, req1_write;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp0_valid, rsp0_error, rsp1_valid, rsp1_error;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [31:0] mem_position, mem_writeData, mem_readData;
  logic        mem_memWrite, mem_memRead, mem_reset;

  dmem_arbiter dut (
    .clock(clock), .reset(reset), .init_req(init_req), .init_busy(init_busy),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_error(rsp0_error),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_error(rsp1_error),
    .mem_position(mem_position), .mem_writeData(mem_writeData),
    .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
    .mem_reset(mem_reset), .mem_readData(mem_readData)
  );

  always #5 clock = ~clock;

  // Memory model
  logic [31:0] mem [32];
  always @(posedge clock) begin
    if (mem_reset) for (int i = 0; i < 32; i++) mem[i] <= i;
    else if (mem_memWrite) mem[mem_position[4:0]] <= mem_writeData;
    if (mem_memRead) mem_readData <= mem[mem_position[4:0]];
  end

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  logic grant_q[$];
  int   errors = 0, checks = 0;
  int   cyc = 0;
  int   rst_cnt = 0, wr_cnt = 0, rd_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each response and tallies strobes
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (rsp0_valid && rsp1_valid) chk("rsp_both_ports", 1, 0);
      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", {31'd0, rsp1_valid}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("rsp_port",    {31'd0, rsp1_valid}, {31'd0, e.port});
          chk("rsp_rdata",   rsp1_valid ? rsp1_rdata : rsp0_rdata, e.rdata);
          chk("rsp_error",   {31'd0, rsp1_valid ? rsp1_error : rsp0_error}, {31'd0, e.err});
          chk("rsp_latency", cyc, e.cyc);
        end
      end
      if (mem_reset) begin
        rst_cnt++;
        chk("ready_in_init", {30'd0, req1_ready, req0_ready}, 0);
      end
      if (mem_memWrite) wr_cnt++;
      if (mem_memRead)  rd_cnt++;
    end
  end

  task automatic set_req(input logic p, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 1'b0) begin
      req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
    end
  endtask

  // Bounded wait for ready (sampled at negedge); returns 1 on success
  task automatic wait_ready(input logic p, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clock);
      if ((p ? req1_ready : req0_ready) === 1'b1) ok = 1'b1;
    end
    if (!ok) chk("ready_timeout", {31'd0, p}, 32'hFFFF_FFFF);
  endtask

  // Issue one request; expected response is pushed at the handshake edge
  task automatic do_req(input logic p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er, input logic ee);
    logic ok;
    exp_t e;
    set_req(p, 1'b1, w, a, d);
    wait_ready(p, ok);
    if (ok) begin
      @(posedge clock); #1;
      e.port = p; e.rdata = er; e.err = ee; e.cyc = cyc + 1;
      sb.push_back(e);
      grant_q.push_back(p);
    end
    set_req(p, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && sb.size() != 0; n++) @(negedge clock);
    chk("drain_empty", sb.size(), 0);
    sb.delete();
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, d0;
    logic ok;
    exp_t e;
    reset = 1'b1; init_req = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 32'd1, 32'd0);   // valid held during reset
    set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready0",    {31'd0, req0_ready}, 0);
    chk("rst_init_busy", {31'd0, init_busy}, 0);
    chk("rst_mem_ctl",   {28'd0, mem_memWrite, mem_memRead, mem_reset, rsp0_valid | rsp1_valid}, 0);
    chk("rst_mem_pos",   mem_position | mem_writeData | rsp0_rdata | rsp1_rdata, 0);
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clock); #1 reset = 1'b0;

    // 1: init then load addr 5
    init_req = 1'b1;
    @(posedge clock); #1 init_req = 1'b0;
    chk("t1_init_busy", {31'd0, init_busy}, 1);
    r0 = rst_cnt;
    do_req(1'b0, 1'b0, 32'd5, 32'd0, 32'd5, 1'b0);
    drain();
    chk("t1_mem_reset_cycles", rst_cnt - r0, 1);
    chk("t1_init_busy_after", {31'd0, init_busy}, 0);

    // 2: store then load back
    w0 = wr_cnt;
    do_req(1'b1, 1'b1, 32'd7, 32'hDEADBEEF, 32'd0, 1'b0);
    do_req(1'b0, 1'b0, 32'd7, 32'd0, 32'hDEADBEEF, 1'b0);
    drain();
    chk("t2_write_cycles", wr_cnt - w0, 1);

    // 3: both ports continuously valid from a fresh reset
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    grant_q.delete();
    fork
      begin
        for (int k = 0; k < 4; k++)
          do_req(1'b0, 1'b0, 32'(10 + k), 32'd0, 32'(10 + k), 1'b0);
      end
      begin
        for (int k = 0; k < 4; k++)
          do_req(1'b1, 1'b1, 32'(20 + k), 32'(256 + k), 32'd0, 1'b0);
      end
    join
    drain();
    chk("t3_grant_count", grant_q.size(), 8);
    for (int k = 0; k < 8 && k < grant_q.size(); k++)
      chk($sformatf("t3_grant%0d", k), {31'd0, grant_q[k]}, k % 2);
    do_req(1'b0, 1'b0, 32'd20, 32'd0, 32'd256, 1'b0);
    do_req(1'b1, 1'b0, 32'd22, 32'd0, 32'd258, 1'b0);
    drain();

    // 4: out-of-range addresses, then the last in-range word
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b0, 1'b0, 32'd32, 32'd0, 32'd0, 1'b1);
    do_req(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1);
    do_req(1'b0, 1'b1, 32'd40, 32'd123, 32'd0, 1'b1);
    drain();
    chk("t4_no_read_strobe",  rd_cnt - r0, 0);
    chk("t4_no_write_strobe", wr_cnt - w0, 0);
    do_req(1'b0, 1'b0, 32'd31, 32'd0, 32'd31, 1'b0);
    drain();

    // 5: init_req during ISSUE of a port-1 store to addr 3
    set_req(1'b1, 1'b1, 1'b1, 32'd3, 32'h55);
    wait_ready(1'b1, ok);
    @(posedge clock); #1;
    e.port = 1'b1; e.rdata = 32'd0; e.err = 1'b0; e.cyc = cyc + 1;
    if (ok) sb.push_back(e);
    set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    init_req = 1'b1;
    @(posedge clock); #1 init_req = 1'b0;
    chk("t5_init_busy", {31'd0, init_busy}, 1);
    r0 = rst_cnt;
    do_req(1'b0, 1'b0, 32'd3, 32'd0, 32'd3, 1'b0);
    drain();
    chk("t5_mem_reset_cycles", rst_cnt - r0, 1);

    // 6: async reset during ISSUE
    set_req(1'b0, 1'b1, 1'b0, 32'd4, 32'd0);
    wait_ready(1'b0, ok);
    @(posedge clock); #1;
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("t6_issue_read", {31'd0, mem_memRead}, 1);
    chk("t6_issue_pos", mem_position, 4);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_strobes", {29'd0, mem_memRead, mem_memWrite, mem_reset}, 0);
    chk("t6_rst_pos", mem_position, 0);
    d0 = cyc;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    chk("t6_no_rsp_queue", sb.size(), 0);
    #1;
    grant_q.delete();
    fork
      do_req(1'b1, 1'b0, 32'd9, 32'd0, 32'd9, 1'b0);
      do_req(1'b0, 1'b0, 32'd8, 32'd0, 32'd8, 1'b0);
    join
    drain();
    chk("t6_grant_count", grant_q.size(), 2);
    if (grant_q.size() == 2) begin
      chk("t6_first_grant",  {31'd0, grant_q[0]}, 0);
      chk("t6_second_grant", {31'd0, grant_q[1]}, 1);
    end
    chk("t6_cycles_sane", {31'd0, (cyc > d0)}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port 32-word data memory between two requesters.
- Port 0 is the datapath load/store unit.
- Port 1 is the program/test loader.
The block handles round-robin arbitration, a valid/ready request handshake and response pulses. It also sequences the memory's synchronous init (the memory's `reset` input) on request. It sits between the requesters and the data memory's position/writeData/memWrite/memRead/reset/readData pins.

Parameters:
- DATA_WIDTH, 32, word width of wdata/rdata.
- ADDR_WIDTH, 32, request address width.
- NUM_WORDS, 32, memory depth; addresses >= NUM_WORDS are out of range.

Ports:
- clock  input  1  system clock, posedge.
- reset  input  1  asynchronous, active-high.
- init_req  input  1  pulse or level: request memory re-initialisation.
- init_busy  output  1  high while an init is pending or in progress.
- req0_valid / req1_valid  input  1  request present.
- req0_ready / req1_ready  output  1  request accepted this cycle when ANDed with valid.
- req0_write / req1_write  input  1  1 = store, 0 = load.
- req0_addr / req1_addr  input  ADDR_WIDTH  word address.
- req0_wdata / req1_wdata  input  DATA_WIDTH  store data.
- rsp0_valid / rsp1_valid  output  1  one-cycle response pulse.
- rsp0_rdata / rsp1_rdata  output  DATA_WIDTH  load data; 0 for stores and errors.
- rsp0_error / rsp1_error  output  1  out-of-range address; valid with rsp_valid.
- mem_position  output  ADDR_WIDTH  to memory `position`.
- mem_writeData  output  DATA_WIDTH  to memory `writeData`.
- mem_memWrite  output  1  to memory `memWrite`.
- mem_memRead  output  1  to memory `memRead`.
- mem_reset  output  1  to memory `reset` (synchronous init).
- mem_readData  input  DATA_WIDTH  from memory `readData`.

Behaviour:
- Reset values (async): state = IDLE, rr_ptr = 0 (port 0 preferred), init_pending = 0. All outputs are 0 and the latched request registers are cleared.
- A reset asserted mid-transaction abandons the transaction; no response is produced.
- FSM states: IDLE, INIT, ISSUE, RESP. State and latched registers are updated on posedge clock; mem_* and rsp_* are decoded from registered state only, with no combinational path from req inputs.
- init_pending is set by init_req in any state and cleared on entry to INIT. init_busy = init_pending OR (state == INIT).
- IDLE, init pending: go to INIT. Both ready outputs are 0; init has priority over requests.
- IDLE, no init pending:
  - Grant is combinational. If only one valid, that port is granted. If both valid, the port equal to rr_ptr is granted. Only the granted port sees ready = 1.
  - On handshake, latch port id, write, addr, wdata; set rr_ptr = the other port; go to ISSUE.
- INIT: mem_reset = 1 for exactly one cycle, then IDLE.
- ISSUE (1 cycle): mem_position = latched addr, mem_writeData = latched wdata.
  - In range (addr < NUM_WORDS): mem_memWrite = write, mem_memRead = !write.
  - Out of range: no strobe; error flag latched.
  - Next state: RESP.
- RESP (1 cycle):
  - rsp_valid pulses on the latched port only.
  - Load: rsp_rdata = mem_readData (the memory registers read data at the end of ISSUE).
  - Store or error: rsp_rdata = 0. rsp_error = latched error flag.
  - Next state: IDLE.
- Latency: handshake at cycle N, mem strobe at N+1, response at N+2. The next grant is possible at N+3, so peak throughput is one access per 3 cycles. There is no response back-pressure.
- mem_* outputs are 0 outside ISSUE/INIT.
- Requesters must hold valid and payload stable until ready.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1.

Decomposition:
- Shared package dmem_pkg holds:
  - state enum (IDLE, INIT, ISSUE, RESP);
  - NUM_WORDS and width constants;
  - port-id constants PORT_DP = 0, PORT_LD = 1.
- One natural sub-module: rr_arbiter2, a 2-input round-robin grant with pointer update on accept.

Test Plan:
1. Assert init_req, then port 0 loads addr 5 -> mem_reset high for one cycle; rsp0_valid two cycles after handshake with rsp0_rdata = 5, rsp0_error = 0.
2. Port 1 stores 0xDEADBEEF to addr 7, then port 0 loads addr 7 -> store rsp1_rdata = 0; the load returns 0xDEADBEEF; mem_memWrite is high for exactly one cycle.
3. Both ports valid continuously for 4 requests each -> grants alternate 0,1,0,1… starting with port 0 after reset; each response appears only on the granting port.
4. Port 0 loads addr 32 -> no mem_memRead/mem_memWrite pulse; rsp0_valid with rsp0_error = 1, rsp0_rdata = 0.
5. init_req during ISSUE of a port 1 store -> the store completes and responds; INIT follows immediately; subsequent load of addr 3 returns 3; ready stays low during INIT.
6. Async reset asserted during ISSUE -> all outputs 0 immediately; no rsp pulse; after release, port 0 is granted first.
